bcd_converter_seq: RTL and testbench
====================================

BCD_CONVERTER_SEQ -- requirements
Module: bcd_converter_seq

Interface
REQ-001 Parameter WIDTH, default 16: binary input width, 4..32.
REQ-002 Parameter DIGITS, default 5: BCD output digit count, 1..10.
REQ-003 Parameter SIGNED, default 0: 1 means in_value is two's complement.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 start  in  1  conversion request; sampled at rising edge.
REQ-007 in_value  in  WIDTH  binary operand; sampled only on accepted start.
REQ-008 ready  out  1  high while idle, meaning start will be accepted.
REQ-009 done  out  1  one-cycle pulse when new results are valid.
REQ-010 out_bcd  out  4*DIGITS  packed BCD, digit 0 in bits [3:0].
REQ-011 out_blank  out  DIGITS  leading-zero blanking mask.
REQ-012 out_neg  out  1  operand was negative; always 0 when SIGNED=0.
REQ-013 out_ovf  out  1  result exceeded DIGITS digits.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE, and ready SHALL equal (state==IDLE).
REQ-015 An edge with state IDLE and start=1 SHALL latch the magnitude and sign, clear the BCD scratch, load shift count WIDTH and enter SHIFT.
REQ-016 Starts in SHIFT or DONE SHALL be ignored without affecting the conversion in flight.
REQ-017 Each SHIFT edge SHALL first add 3 to every scratch digit >=5, then shift {scratch, operand} left one bit, MSB-first.
REQ-018 A bit shifted out of the top scratch digit SHALL set a sticky overflow flag, cleared on accept.
REQ-019 The WIDTH-th shift edge SHALL write out_bcd, out_blank, out_neg and out_ovf, then enter DONE.
REQ-020 done SHALL be high only in DONE, which lasts exactly one cycle and then returns to IDLE.
REQ-021 With the accept edge as edge 0, done SHALL be high between edges WIDTH and WIDTH+1.
REQ-022 Back-to-back throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-023 Outputs other than ready and done SHALL hold their value until the next completion.
REQ-024 out_blank bit d (d>=1) SHALL be 1 iff digit d and all higher digits are zero; bit 0 SHALL always be 0.
REQ-025 When SIGNED=1 and in_value is negative, the magnitude SHALL be -in_value taken as WIDTH-bit unsigned, so -2^(WIDTH-1) converts exactly, and out_neg SHALL be 1.
REQ-026 On overflow, out_bcd SHALL hold the low DIGITS digits of the true result, and out_ovf SHALL be 1.

Reset
REQ-027 On reset=1 the block SHALL go to IDLE with out_bcd=0, out_blank={DIGITS-1 ones,0}, out_neg=0, out_ovf=0, done=0 and shift count=0.
REQ-028 Reset during SHIFT or DONE SHALL abort with no done pulse, and ready SHALL be 1 in the cycle after the reset edge.
REQ-029 Reset SHALL take priority over a simultaneous start.

Structure
REQ-030 Package bcd_pkg SHALL hold the FSM state encoding, the add-3 threshold constant (5) and the digit-width constant (4).
REQ-031 Sub-module bcd_digit_adj SHALL implement the combinational per-digit add-3 step, instantiated DIGITS times via generate.
REQ-032 The shift counter SHALL be clog2(WIDTH+1) bits wide.

Verification
REQ-033 WIDTH=16, DIGITS=5: start with 65535 -> done 16 cycles after accept, out_bcd=0x65535, out_blank=00000, out_ovf=0.
REQ-034 in_value=0 -> out_bcd=0x00000, out_blank=11110; then in_value=1234 -> out_bcd=0x01234, out_blank=10000.
REQ-035 start held high with in_value changing every cycle -> only values sampled while ready=1 are converted; one done per conversion, 18 cycles apart.
REQ-036 Reset asserted after the 8th shift -> no done pulse, ready=1 next cycle, out_bcd=0; the next start converts correctly.
REQ-037 SIGNED=1, WIDTH=8, DIGITS=3: -128 -> out_bcd=0x128, out_neg=1; 127 -> out_bcd=0x127, out_neg=0.
REQ-038 WIDTH=8, DIGITS=2: 255 -> out_bcd=0x55, out_ovf=1; the following 99 -> out_bcd=0x99, out_ovf=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding and the double-dabble digit constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ADD3_THRESH = 5;
    localparam int DIGIT_W     = 4;

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Request/result bundle of the BCD converter. The requester drives start and
// in_value; the converter returns ready, the done pulse and the held results.
interface bcd_converter_seq_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);

    logic                      start;
    logic [WIDTH-1:0]          in_value;
    logic                      ready;
    logic                      done;
    logic [DIGIT_W*DIGITS-1:0] out_bcd;
    logic [DIGITS-1:0]         out_blank;
    logic                      out_neg;
    logic                      out_ovf;

    modport master (
        output start, in_value,
        input  ready, done, out_bcd, out_blank, out_neg, out_ovf
    );

    modport slave (
        input  start, in_value,
        output ready, done, out_bcd, out_blank, out_neg, out_ovf
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction step: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    assign adj = (digit >= DIGIT_W'(ADD3_THRESH)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per
// clock, with sign handling, leading-zero blanking mask and overflow flag.
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    bcd_converter_seq_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = DIGIT_W * DIGITS;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        operand;
    logic [WIDTH-1:0]        operand_nxt;
    logic [BCD_W-1:0]        scratch;
    logic [BCD_W-1:0]        scratch_adj;
    logic [BCD_W-1:0]        scratch_nxt;
    logic                    carry;
    logic                    ovf_sticky;
    logic                    neg;

    logic signed [WIDTH-1:0] in_signed;
    logic [WIDTH-1:0]        magnitude;
    logic                    in_neg;
    logic                    accept;
    logic                    last_shift;

    logic                    ready;
    logic                    done;
    logic [BCD_W-1:0]        out_bcd;
    logic [DIGITS-1:0]       out_blank;
    logic                    out_neg;
    logic                    out_ovf;

    // Bit d set when digit d and every digit above it are zero; digit 0 is never blanked.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_above = zero_above && (bcd[d*DIGIT_W +: DIGIT_W] == '0);
            m[d]       = zero_above;
        end
        return m;
    endfunction

    // Negating in WIDTH bits lets the most negative value come out as its exact magnitude.
    assign in_signed = bus.in_value;
    assign in_neg    = (SIGNED != 0) && in_signed[WIDTH-1];
    assign magnitude = in_neg ? $unsigned(-in_signed) : bus.in_value;

    assign accept     = (state == ST_IDLE) && bus.start;
    assign last_shift = (state == ST_SHIFT) && (cnt == CNT_W'(1));

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit (scratch[d*DIGIT_W +: DIGIT_W]),
            .adj   (scratch_adj[d*DIGIT_W +: DIGIT_W])
        );
    end

    assign {carry, scratch_nxt, operand_nxt} = {scratch_adj, operand, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE);
        done  = (state == ST_DONE);
    end

    // Control and visible results: cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            neg        <= 1'b0;
            out_bcd    <= '0;
            out_blank  <= blank_mask('0);
            out_neg    <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (accept) begin
            cnt        <= CNT_W'(WIDTH);
            ovf_sticky <= 1'b0;
            neg        <= in_neg;
        end else if (state == ST_SHIFT) begin
            cnt        <= cnt - 1'b1;
            ovf_sticky <= ovf_sticky | carry;
            if (last_shift) begin
                out_bcd   <= scratch_nxt;
                out_blank <= blank_mask(scratch_nxt);
                out_neg   <= neg;
                out_ovf   <= ovf_sticky | carry;
            end
        end
    end

    // Working datapath: only meaningful between accept and completion.
    always_ff @(posedge clk) begin
        if (accept) begin
            operand <= magnitude;
            scratch <= '0;
        end else if (state == ST_SHIFT) begin
            operand <= operand_nxt;
            scratch <= scratch_nxt;
        end
    end

    assign bus.ready     = ready;
    assign bus.done      = done;
    assign bus.out_bcd   = out_bcd;
    assign bus.out_blank = out_blank;
    assign bus.out_neg   = out_neg;
    assign bus.out_ovf   = out_ovf;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench for bcd_converter_seq in three configurations, checked
// against an arithmetic (divide/modulo) reference model.
module tb_bcd_converter_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [39:0] bcd;
        logic [9:0]  blank;
        logic        neg;
        logic        ovf;
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bcd_converter_seq_if #(.WIDTH(16), .DIGITS(5)) b0 ();
    bcd_converter_seq_if #(.WIDTH(8),  .DIGITS(3)) b1 ();
    bcd_converter_seq_if #(.WIDTH(8),  .DIGITS(2)) b2 ();

    bcd_converter_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    bcd_converter_seq #(.WIDTH(8),  .DIGITS(3), .SIGNED(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    bcd_converter_seq #(.WIDTH(8),  .DIGITS(2), .SIGNED(0)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

    function automatic int cfg_w(int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic int cfg_d(int k);
        return (k == 0) ? 5 : (k == 1) ? 3 : 2;
    endfunction

    function automatic bit cfg_s(int k);
        return (k == 1);
    endfunction

    // Reference: magnitude by plain arithmetic, digits by repeated divide/modulo.
    function automatic exp_t model(int k, logic [31:0] v);
        exp_t   e;
        int     w;
        int     d;
        longint mag;
        longint lim;
        longint low;
        longint pi;
        w   = cfg_w(k);
        d   = cfg_d(k);
        mag = longint'(v) & ((longint'(1) << w) - 1);
        e.neg = cfg_s(k) && v[w-1];
        if (e.neg) mag = (longint'(1) << w) - mag;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        e.ovf   = (mag >= lim);
        low     = mag % lim;
        e.bcd   = '0;
        e.blank = '0;
        pi      = 1;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'((low / pi) % 10);
            if (i >= 1) e.blank[i] = ((low / pi) == 0);
            pi = pi * 10;
        end
        e.cyc = 0;
        e.val = v;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(int k, logic s, logic [31:0] v);
        case (k)
            0:       begin b0.start = s; b0.in_value = v[15:0]; end
            1:       begin b1.start = s; b1.in_value = v[7:0];  end
            default: begin b2.start = s; b2.in_value = v[7:0];  end
        endcase
    endtask

    function automatic logic rdy(int k);
        case (k)
            0:       return b0.ready;
            1:       return b1.ready;
            default: return b2.ready;
        endcase
    endfunction

    task automatic push(int k, exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mon(int k, logic [39:0] bcd, logic [9:0] blank, logic neg, logic ovf);
        exp_t e;
        if (qsize(k) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d unexpected_done: got done=1 expected done=0", k);
            return;
        end
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check($sformatf("dut%0d bcd(in=%0h)", k, e.val),   64'(bcd),   64'(e.bcd));
        check($sformatf("dut%0d blank(in=%0h)", k, e.val), 64'(blank), 64'(e.blank));
        check($sformatf("dut%0d neg(in=%0h)", k, e.val),   64'(neg),   64'(e.neg));
        check($sformatf("dut%0d ovf(in=%0h)", k, e.val),   64'(ovf),   64'(e.ovf));
        check($sformatf("dut%0d done_cycle(in=%0h)", k, e.val), 64'(cyc), 64'(e.cyc));
    endtask

    always @(negedge clk) if (b0.done === 1'b1) mon(0, 40'(b0.out_bcd), 10'(b0.out_blank), b0.out_neg, b0.out_ovf);
    always @(negedge clk) if (b1.done === 1'b1) mon(1, 40'(b1.out_bcd), 10'(b1.out_blank), b1.out_neg, b1.out_ovf);
    always @(negedge clk) if (b2.done === 1'b1) mon(2, 40'(b2.out_bcd), 10'(b2.out_blank), b2.out_neg, b2.out_ovf);

    // Issue one request when the converter is idle; done is expected WIDTH edges after accept.
    task automatic convert(int k, logic [31:0] v);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!rdy(k) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy(k)) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d ready_timeout: got ready=0 expected ready=1", k);
            return;
        end
        e     = model(k, v);
        e.cyc = cyc + 1 + cfg_w(k);
        push(k, e);
        set_in(k, 1'b1, v);
        @(negedge clk);
        set_in(k, 1'b0, 32'd0);
    endtask

    // start held high while in_value changes every cycle; only idle-cycle values count.
    task automatic stream(int k, int n);
        exp_t        e;
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = $urandom;
            set_in(k, 1'b1, v);
            if (rdy(k)) begin
                e     = model(k, v);
                e.cyc = cyc + 1 + cfg_w(k);
                push(k, e);
            end
        end
        @(negedge clk);
        set_in(k, 1'b0, 32'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
            q0.delete();
            q1.delete();
            q2.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst ready0", 64'(b0.ready), 64'd1);
        check("rst done0",  64'(b0.done),  64'd0);
        check("rst bcd0",   64'(b0.out_bcd), 64'd0);
        check("rst blank0", 64'(b0.out_blank), 64'b11110);
        check("rst neg0",   64'(b0.out_neg), 64'd0);
        check("rst ovf0",   64'(b0.out_ovf), 64'd0);
        check("rst blank1", 64'(b1.out_blank), 64'b110);
        check("rst blank2", 64'(b2.out_blank), 64'b10);
        reset = 1'b0;

        convert(0, 32'd65535);
        convert(0, 32'd0);
        convert(0, 32'd1234);
        drain();
        repeat (5) @(negedge clk);
        check("hold bcd0",   64'(b0.out_bcd),   64'h01234);
        check("hold blank0", 64'(b0.out_blank), 64'b10000);

        convert(1, 32'h80);
        convert(1, 32'd127);
        convert(1, 32'd0);
        convert(2, 32'd255);
        convert(2, 32'd99);
        convert(2, 32'd100);
        drain();

        for (int i = 0; i < 15; i++) begin
            convert(0, $urandom);
            convert(1, $urandom);
            convert(2, $urandom);
        end
        drain();

        stream(0, 60);
        stream(1, 30);
        stream(2, 30);
        drain();

        // Abort after the 8th shift edge: no done, back to idle with cleared result.
        convert(0, 32'd54321);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        void'(q0.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("abort ready0", 64'(b0.ready),   64'd1);
        check("abort done0",  64'(b0.done),    64'd0);
        check("abort bcd0",   64'(b0.out_bcd), 64'd0);
        repeat (20) @(negedge clk);
        convert(0, 32'd4321);
        drain();

        // Reset wins over a start on the same edge.
        @(negedge clk);
        set_in(0, 1'b1, 32'd77);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 1'b0, 32'd0);
        check("rst_prio ready0", 64'(b0.ready), 64'd1);
        repeat (20) @(negedge clk);
        convert(0, 32'd9);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
